// File: rtl/mips_control_fsm.sv
// mips_control_fsm: multicycle MIPS main control unit (Moore FSM driving datapath enables and selects)
// Ports:
//   clk, reset (sync, active-high)
//   opcode, funct   - instruction fields from the IR
//   zero, overflow  - same-cycle ALU flags
//   pcWrite, iorD, memRead, memWrite, irWrite, regWrite, regDst, memToReg,
//   aluSrcA, aluSrcB, aluOpCode, pcSource, epcWrite, causeWrite - datapath controls
//   intCause        - registered trap cause (0 undefined, 1 overflow)
//   state           - current state, for debug
module mips_control_fsm #(
    parameter int EXC_ENABLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pcWrite,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [3:0] aluOpCode,
    output logic [1:0] pcSource,
    output logic       epcWrite,
    output logic       causeWrite,
    output logic       intCause,
    output logic [3:0] state
);
    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0100, ALU_SRL = 4'b0101, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100;
    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05, OP_J = 6'h02, OP_ADDI = 6'h08;

    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADDR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
        MEMWRITE = 4'd5, EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
        ADDIEX = 4'd10, ADDIWB = 4'd11, EXCEPT = 4'd12
    } state_t;

    localparam bit EXC = (EXC_ENABLE != 0);
    localparam state_t TRAP = EXC ? EXCEPT : FETCH;

    state_t cur, nxt;
    logic   cause_q;
    logic   r_ok, r_arith;
    logic [3:0] r_op;

    assign r_ok    = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02};
    assign r_arith = (funct == 6'h20) || (funct == 6'h22);
    assign r_op    = funct == 6'h22 ? ALU_SUB :
                     funct == 6'h24 ? ALU_AND :
                     funct == 6'h25 ? ALU_OR  :
                     funct == 6'h27 ? ALU_NOR :
                     funct == 6'h2A ? ALU_SLT :
                     funct == 6'h00 ? ALU_SLL :
                     funct == 6'h02 ? ALU_SRL : ALU_ADD;
    assign intCause = cause_q;
    assign state    = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= FETCH;
            cause_q <= 1'b0;
        end else begin
            cur <= nxt;
            // only EXEC/ADDIEX reach EXCEPT via overflow; DECODE reaches it via undefined instruction
            if (nxt == EXCEPT) cause_q <= (cur == EXEC) || (cur == ADDIEX);
        end
    end

    always_comb begin
        nxt        = FETCH;
        pcWrite    = 1'b0;
        iorD       = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regWrite   = 1'b0;
        regDst     = 1'b0;
        memToReg   = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = 2'b00;
        aluOpCode  = ALU_ADD;
        pcSource   = 2'b00;
        epcWrite   = 1'b0;
        causeWrite = 1'b0;
        case (cur)
            FETCH: begin
                memRead = 1'b1;
                irWrite = 1'b1;
                aluSrcB = 2'b01;
                pcWrite = 1'b1;
                nxt     = DECODE;
            end
            DECODE: begin
                aluSrcB = 2'b11;
                nxt = opcode == OP_R ? (r_ok ? EXEC : TRAP) :
                      (opcode == OP_LW || opcode == OP_SW) ? MEMADDR :
                      (opcode == OP_BEQ || opcode == OP_BNE) ? BRANCH :
                      opcode == OP_J ? JUMP :
                      opcode == OP_ADDI ? ADDIEX : TRAP;
            end
            MEMADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                nxt     = opcode == OP_SW ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                nxt     = MEMWB;
            end
            MEMWB: begin
                memToReg = 1'b1;
                regWrite = 1'b1;
            end
            MEMWRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            EXEC: begin
                aluSrcA   = 1'b1;
                aluOpCode = r_op;
                nxt       = (EXC && r_arith && overflow) ? EXCEPT : RWB;
            end
            RWB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
            end
            BRANCH: begin
                aluSrcA   = 1'b1;
                aluOpCode = ALU_SUB;
                pcSource  = 2'b01;
                pcWrite   = opcode == OP_BNE ? ~zero : zero;
            end
            JUMP: begin
                pcSource = 2'b10;
                pcWrite  = 1'b1;
            end
            ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                nxt     = (EXC && overflow) ? EXCEPT : ADDIWB;
            end
            ADDIWB: regWrite = 1'b1;
            EXCEPT: begin
                aluSrcB    = 2'b01;
                aluOpCode  = ALU_SUB;
                epcWrite   = 1'b1;
                causeWrite = 1'b1;
                pcSource   = 2'b11;
                pcWrite    = 1'b1;
            end
            default: nxt = FETCH;
        endcase
        // reset suppresses every enable; selects keep following the state
        if (reset) begin
            pcWrite    = 1'b0;
            irWrite    = 1'b0;
            memRead    = 1'b0;
            memWrite   = 1'b0;
            regWrite   = 1'b0;
            epcWrite   = 1'b0;
            causeWrite = 1'b0;
        end
    end
endmodule

// File: tb/tb_mips_control_fsm.sv
// tb_mips_control_fsm: directed self-checking bench for mips_control_fsm (EXC_ENABLE=1 and 0)
module tb_mips_control_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h20;
    logic       zero = 1'b0;
    logic       overflow = 1'b0;

    logic       pc_we1, iord1, mrd1, mwr1, irw1, rw1, rdst1, m2r1, sa1, epc1, cw1, ic1;
    logic [1:0] sb1, ps1;
    logic [3:0] op1, st1;
    logic       pc_we0, iord0, mrd0, mwr0, irw0, rw0, rdst0, m2r0, sa0, epc0, cw0, ic0;
    logic [1:0] sb0, ps0;
    logic [3:0] op0, st0;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mips_control_fsm #(.EXC_ENABLE(1)) d1 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
        .pcWrite(pc_we1), .iorD(iord1), .memRead(mrd1), .memWrite(mwr1), .irWrite(irw1),
        .regWrite(rw1), .regDst(rdst1), .memToReg(m2r1), .aluSrcA(sa1), .aluSrcB(sb1),
        .aluOpCode(op1), .pcSource(ps1), .epcWrite(epc1), .causeWrite(cw1), .intCause(ic1), .state(st1)
    );

    mips_control_fsm #(.EXC_ENABLE(0)) d0 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
        .pcWrite(pc_we0), .iorD(iord0), .memRead(mrd0), .memWrite(mwr0), .irWrite(irw0),
        .regWrite(rw0), .regDst(rdst0), .memToReg(m2r0), .aluSrcA(sa0), .aluSrcB(sb0),
        .aluOpCode(op0), .pcSource(ps0), .epcWrite(epc0), .causeWrite(cw0), .intCause(ic0), .state(st0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        overflow = 1'b0;
        zero = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    logic [5:0] fn_tab [6] = '{6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02};
    logic [3:0] op_tab [6] = '{4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b0100, 4'b0101};

    initial begin
        // reset held for two edges: FETCH, enables forced off
        tick();
        chk("rst_state_a", st1, 4'd0);
        chk("rst_memread_a", mrd1, 1'b0);
        tick();
        chk("rst_state", st1, 4'd0);
        chk("rst_memread", mrd1, 1'b0);
        chk("rst_irwrite", irw1, 1'b0);
        chk("rst_pcwrite", pc_we1, 1'b0);
        chk("rst_intcause", ic1, 1'b0);
        chk("rst_alusrcb", sb1, 2'b01);
        reset = 1'b0;
        #1;
        chk("fetch_memread", mrd1, 1'b1);
        chk("fetch_irwrite", irw1, 1'b1);
        chk("fetch_pcwrite", pc_we1, 1'b1);
        chk("fetch_aluop", op1, 4'b0010);
        chk("fetch_pcsource", ps1, 2'b00);

        // lw: 0,1,2,3,4,0
        opcode = 6'h23;
        tick(); chk("lw_s1", st1, 4'd1); chk("lw_decode_srcb", sb1, 2'b11);
        tick(); chk("lw_s2", st1, 4'd2); chk("lw_memaddr_srcb", sb1, 2'b10); chk("lw_memaddr_srca", sa1, 1'b1);
        tick(); chk("lw_s3", st1, 4'd3); chk("lw_iord", iord1, 1'b1); chk("lw_memread", mrd1, 1'b1);
        tick(); chk("lw_s4", st1, 4'd4); chk("lw_regwrite", rw1, 1'b1); chk("lw_memtoreg", m2r1, 1'b1);
        tick(); chk("lw_s0", st1, 4'd0);

        // sw: 0,1,2,5,0
        opcode = 6'h2B;
        tick(); chk("sw_s1", st1, 4'd1);
        tick(); chk("sw_s2", st1, 4'd2);
        tick(); chk("sw_s5", st1, 4'd5); chk("sw_memwrite", mwr1, 1'b1); chk("sw_iord", iord1, 1'b1);
        tick(); chk("sw_s0", st1, 4'd0);

        // add with overflow: trap on d1, write-back on d0
        do_reset();
        opcode = 6'h00; funct = 6'h20;
        tick(); chk("ovf_s1", st1, 4'd1); chk("ovf_rw_s1", rw1, 1'b0);
        tick(); overflow = 1'b1; #1;
        chk("ovf_s6", st1, 4'd6); chk("ovf_rw_s6", rw1, 1'b0); chk("ovf_d0_s6", st0, 4'd6);
        tick(); overflow = 1'b0; #1;
        chk("ovf_s12", st1, 4'd12); chk("ovf_intcause", ic1, 1'b1); chk("ovf_epc", epc1, 1'b1);
        chk("ovf_cause_we", cw1, 1'b1); chk("ovf_pcsource", ps1, 2'b11); chk("ovf_aluop", op1, 4'b0110);
        chk("ovf_pcwrite", pc_we1, 1'b1); chk("ovf_rw_s12", rw1, 1'b0); chk("ovf_srcb", sb1, 2'b01);
        chk("noexc_s7", st0, 4'd7); chk("noexc_rw", rw0, 1'b1); chk("noexc_regdst", rdst0, 1'b1);
        tick(); chk("ovf_s0", st1, 4'd0); chk("noexc_s0", st0, 4'd0);

        // add without overflow goes to RWB; cause register holds
        tick(); chk("add_s1", st1, 4'd1);
        tick(); chk("add_s6", st1, 4'd6); chk("add_aluop", op1, 4'b0010);
        tick(); chk("add_s7", st1, 4'd7); chk("add_rw", rw1, 1'b1); chk("add_cause_hold", ic1, 1'b1);
        tick(); chk("add_s0", st1, 4'd0);

        // undefined opcode straight after an overflow trap: cause reloads 0
        opcode = 6'h3F;
        tick(); chk("undef_s1", st1, 4'd1);
        tick(); chk("undef_s12", st1, 4'd12); chk("undef_intcause", ic1, 1'b0); chk("undef_d0_fetch", st0, 4'd0);
        tick(); chk("undef_s0", st1, 4'd0);

        // undecoded R funct 0x2B
        do_reset();
        opcode = 6'h00; funct = 6'h2B;
        tick(); chk("rbad_s1", st1, 4'd1);
        tick(); chk("rbad_s12", st1, 4'd12); chk("rbad_intcause", ic1, 1'b0);
        tick(); chk("rbad_s0", st1, 4'd0);

        // sub overflow with EXC_ENABLE
        funct = 6'h22;
        tick(); tick(); overflow = 1'b1; #1;
        chk("sub_aluop", op1, 4'b0110);
        tick(); overflow = 1'b0; #1;
        chk("sub_s12", st1, 4'd12); chk("sub_intcause", ic1, 1'b1);
        tick();

        // R funct ALU decoding; overflow ignored for logical ops
        do_reset();
        opcode = 6'h00;
        for (int i = 0; i < 6; i++) begin
            funct = fn_tab[i];
            tick();
            tick(); overflow = 1'b1; #1;
            chk($sformatf("rop_%0h_aluop", fn_tab[i]), op1, op_tab[i]);
            tick(); overflow = 1'b0; #1;
            chk($sformatf("rop_%0h_s7", fn_tab[i]), st1, 4'd7);
            tick();
        end

        // beq/bne
        do_reset();
        opcode = 6'h04;
        tick(); tick(); zero = 1'b1; #1;
        chk("beq_s8", st1, 4'd8); chk("beq_z1_pcwrite", pc_we1, 1'b1); chk("beq_pcsource", ps1, 2'b01);
        chk("beq_aluop", op1, 4'b0110);
        zero = 1'b0; #1;
        chk("beq_z0_pcwrite", pc_we1, 1'b0);
        tick(); chk("beq_s0", st1, 4'd0);
        opcode = 6'h05;
        tick(); tick(); zero = 1'b0; #1;
        chk("bne_z0_pcwrite", pc_we1, 1'b1); chk("bne_pcsource", ps1, 2'b01);
        zero = 1'b1; #1;
        chk("bne_z1_pcwrite", pc_we1, 1'b0);
        tick(); zero = 1'b0; chk("bne_s0", st1, 4'd0);

        // j
        opcode = 6'h02;
        tick(); tick();
        chk("j_s9", st1, 4'd9); chk("j_pcsource", ps1, 2'b10); chk("j_pcwrite", pc_we1, 1'b1);
        tick(); chk("j_s0", st1, 4'd0);

        // addi with overflow
        opcode = 6'h08;
        tick(); tick(); overflow = 1'b1; #1;
        chk("addi_s10", st1, 4'd10); chk("addi_srcb", sb1, 2'b10);
        tick(); overflow = 1'b0; #1;
        chk("addi_s12", st1, 4'd12); chk("addi_intcause", ic1, 1'b1); chk("addi_d0_s11", st0, 4'd11);
        chk("addi_d0_rw", rw0, 1'b1);
        tick();

        // reset mid-lw aborts
        do_reset();
        opcode = 6'h23;
        tick(); tick(); tick();
        chk("abort_s3", st1, 4'd3);
        reset = 1'b1; #1;
        chk("abort_memread", mrd1, 1'b0); chk("abort_iord", iord1, 1'b1);
        tick(); chk("abort_state", st1, 4'd0); chk("abort_rw", rw1, 1'b0); chk("abort_pcwrite", pc_we1, 1'b0);
        reset = 1'b0; #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
